// File: rtl/tapdelay_line.sv
// rtl/tapdelay_line.sv - circular tap buffer streaming the last NUM_TAPS samples newest-first
module tapdelay_line #(
    parameter int DATA_W   = 16,
    parameter int NUM_TAPS = 17,
    parameter int PTR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [PTR_W-1:0]  out_tap,
    output logic              out_last,
    input  logic              out_ready,
    output logic [PTR_W:0]    fill_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [PTR_W-1:0] LAST_TAP   = PTR_W'(NUM_TAPS - 1);
    localparam logic [PTR_W-1:0] TAPS_MOD   = PTR_W'(NUM_TAPS);
    localparam logic [PTR_W:0]   NUM_TAPS_W = (PTR_W + 1)'(NUM_TAPS);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   newest_q, newest_d;
    logic [PTR_W-1:0]   tap_q, tap_d;
    logic [PTR_W:0]     fill_q, fill_d;
    logic [DATA_W-1:0]  mem [NUM_TAPS];

    logic               wr_en;
    logic [PTR_W:0]     diff;
    logic [PTR_W-1:0]   rd_idx;

    assign wr_en = (state_q == IDLE) && in_valid;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        newest_d = newest_q;
        tap_d    = tap_q;
        fill_d   = fill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    newest_d = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
                    fill_d   = (fill_q == NUM_TAPS_W) ? fill_q : fill_q + 1'b1;
                    tap_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (tap_q == LAST_TAP) begin
                        tap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            newest_q <= '0;
            tap_q    <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            newest_q <= newest_d;
            tap_q    <= tap_d;
            fill_q   <= fill_d;
        end
    end

    // Memory is unreset; stale entries are hidden by the fill_count mask on the read side.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Asynchronous read: the sample written at the accept edge is visible on beat 0 directly.
    assign diff   = {1'b0, newest_q} - {1'b0, tap_q};
    assign rd_idx = diff[PTR_W] ? (diff[PTR_W-1:0] + TAPS_MOD) : diff[PTR_W-1:0];

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == STREAM);
    assign out_tap    = tap_q;
    assign out_last   = (state_q == STREAM) && (tap_q == LAST_TAP);
    assign out_data   = ((state_q == STREAM) && ({1'b0, tap_q} < fill_q)) ? mem[rd_idx] : '0;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_tapdelay_line.sv
// tb/tb_tapdelay_line.sv - directed bench for tapdelay_line
module tb_tapdelay_line;

    localparam int DATA_W   = 16;
    localparam int NUM_TAPS = 17;
    localparam int PTR_W    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [PTR_W-1:0]  out_tap;
    logic              out_last;
    logic              out_ready;
    logic [PTR_W:0]    fill_count;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] hist [NUM_TAPS];
    int                model_fill;

    tapdelay_line #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tap   (out_tap),
        .out_last  (out_last),
        .out_ready (out_ready),
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_fill = 0;
        for (int i = 0; i < NUM_TAPS; i++) hist[i] = '0;
    endtask

    task automatic model_push(input logic [DATA_W-1:0] v);
        for (int i = NUM_TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        if (model_fill < NUM_TAPS) model_fill++;
    endtask

    function automatic logic [DATA_W-1:0] exp_tap(input int k);
        return (k < model_fill) ? hist[k] : '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One frame; stall_tap stalls out_ready for 3 cycles at that beat, abort_tap pulses rst there.
    task automatic do_frame(input logic [DATA_W-1:0] v, input int stall_tap, input int abort_tap,
                            input bit full_check);
        logic [DATA_W-1:0] held;
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        model_push(v);
        check("fill_count", fill_count, model_fill);
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (k == abort_tap) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                check("abort_out_valid", out_valid, 0);
                check("abort_in_ready", in_ready, 1);
                check("abort_fill", fill_count, 0);
                return;
            end
            if (full_check || k == 0 || k == NUM_TAPS - 1 || k == NUM_TAPS - 2) begin
                check($sformatf("valid_t%0d", k), out_valid, 1);
                check($sformatf("tap_t%0d", k), out_tap, k);
                check($sformatf("data_t%0d", k), out_data, exp_tap(k));
                check($sformatf("last_t%0d", k), out_last, (k == NUM_TAPS - 1));
            end
            if (k == stall_tap) begin
                held      = out_data;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 16'hBEEF;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check("stall_tap", out_tap, k);
                    check("stall_data", out_data, held);
                    check("stall_in_ready", in_ready, 0);
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("end_out_valid", out_valid, 0);
        check("end_in_ready", in_ready, 1);
        check("end_fill", fill_count, model_fill);
    endtask

    initial begin
        int accepts [$];
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tap", out_tap, 0);
        check("rst_out_last", out_last, 0);
        check("rst_fill", fill_count, 0);
        rst = 1'b0;
        @(negedge clk);

        do_frame(16'h0011, -1, -1, 1'b1);

        do_reset();
        for (int i = 1; i <= 17; i++) do_frame(DATA_W'(i), -1, -1, (i == 17));
        check("fill_17", fill_count, 17);

        do_frame(16'd18, -1, -1, 1'b1);
        check("fill_sat", fill_count, 17);

        do_frame(16'h0019, 5, -1, 1'b1);

        do_frame(16'h0020, -1, 8, 1'b0);
        do_frame(16'h0042, -1, -1, 1'b1);

        in_valid  = 1'b1;
        in_data   = 16'h0100;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 60; cyc++) begin
            if (in_ready) begin
                accepts.push_back(cyc);
            end
            @(negedge clk);
            if (accepts.size() > 0 && accepts[accepts.size()-1] == cyc) in_data = in_data + 1'b1;
        end
        in_valid = 1'b0;
        check("cont_accepts", accepts.size(), 4);
        for (int i = 1; i < accepts.size(); i++)
            check($sformatf("cont_gap%0d", i), accepts[i] - accepts[i-1], NUM_TAPS + 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
